// File: rtl/alu_seq_param.sv
// Parametrised ALU with a start/valid handshake. Logic and arithmetic ops finish in one
// cycle; unsigned MOD runs a restoring shift-subtract loop, one dividend bit per cycle.
module alu_seq_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       Aluop,
    output logic [WIDTH-1:0] result,
    output logic             valid,
    output logic             busy,
    output logic             ovf,
    output logic             div_by_zero
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_MOD_RUN = 1'b1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MOD = 3'b111;

    logic [0:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] rem;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ovf;

    logic [WIDTH-1:0] trial_lo;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;

    assign busy = (state == S_MOD_RUN);
    assign sum  = A + B;
    assign diff = A - B;

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (Aluop)
            OP_AND: alu_res = A & B;
            OP_OR:  alu_res = A | B;
            OP_XOR: alu_res = A ^ B;
            OP_NOR: alu_res = ~(A | B);
            OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            default: alu_res = '0;
        endcase
    end

    // The shifted partial remainder is WIDTH+1 bits; its top bit is rem's MSB, and when
    // set the value already exceeds B, so the W-bit wrapped subtraction is exact.
    always_comb begin
        trial_lo = {rem[WIDTH-2:0], a_sh[WIDTH-1]};
        trial_ge = rem[WIDTH-1] || (trial_lo >= b_reg);
        rem_next = trial_ge ? (trial_lo - b_reg) : trial_lo;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            result      <= '0;
            valid       <= 1'b0;
            ovf         <= 1'b0;
            div_by_zero <= 1'b0;
            a_sh        <= '0;
            b_reg       <= '0;
            rem         <= '0;
            cnt         <= '0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (Aluop == OP_MOD) begin
                            if (B == '0) begin
                                result      <= A;
                                valid       <= 1'b1;
                                ovf         <= 1'b0;
                                div_by_zero <= 1'b1;
                            end else begin
                                a_sh  <= A;
                                b_reg <= B;
                                rem   <= '0;
                                cnt   <= CNT_W'(WIDTH - 1);
                                state <= S_MOD_RUN;
                            end
                        end else begin
                            result      <= alu_res;
                            ovf         <= alu_ovf;
                            div_by_zero <= 1'b0;
                            valid       <= 1'b1;
                        end
                    end
                end
                S_MOD_RUN: begin
                    rem  <= rem_next;
                    a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                    cnt  <= cnt - CNT_W'(1);
                    if (cnt == '0) begin
                        result      <= rem_next;
                        valid       <= 1'b1;
                        ovf         <= 1'b0;
                        div_by_zero <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_param.sv
// Directed bench for alu_seq_param: a 32-bit instance and an 8-bit instance share clock
// and reset; expected values are hand-computed constants.
module tb_alu_seq_param;

    logic        clk;
    logic        reset;

    logic        start;
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [31:0] res;
    logic        valid, busy, ovf, dbz;

    logic        start8;
    logic [7:0]  a8, b8;
    logic [2:0]  op8;
    logic [7:0]  res8;
    logic        valid8, busy8, ovf8, dbz8;

    int checks = 0;
    int errors = 0;

    alu_seq_param #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .Aluop(op),
        .result(res), .valid(valid), .busy(busy), .ovf(ovf), .div_by_zero(dbz)
    );

    alu_seq_param #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .A(a8), .B(b8), .Aluop(op8),
        .result(res8), .valid(valid8), .busy(busy8), .ovf(ovf8), .div_by_zero(dbz8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits for valid on the selected instance; lat = edges after the start edge, -1 on timeout.
    task automatic wait_valid(input bit sel8, output int lat);
        lat = -1;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if ((sel8 && valid8) || (!sel8 && valid)) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic issue32(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    logic [31:0] exp1 [7];
    int          lat;
    int          vcnt;
    int          bcnt;
    int          vat;
    logic [31:0] res_at;
    logic        dbz_at;

    initial begin
        exp1[0] = 32'd3;  exp1[1] = 32'd47; exp1[2] = 32'd44; exp1[3] = 32'hFFFF_FFD0;
        exp1[4] = 32'd0;  exp1[5] = 32'd50; exp1[6] = 32'd20;

        reset = 1'b1;
        start = 1'b0; a = '0; b = '0; op = '0;
        start8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", res, 0);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_ovf", ovf, 0);
        check("reset_dbz", dbz, 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Back-to-back single-cycle ops
        for (int i = 0; i < 7; i++) begin
            a = 32'd35; b = 32'd15; op = 3'(i); start = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("op%0d_valid", i), valid, 1);
            check($sformatf("op%0d_result", i), res, exp1[i]);
            check($sformatf("op%0d_busy", i), busy, 0);
            check($sformatf("op%0d_ovf", i), ovf, 0);
        end
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_valid_low", valid, 0);
        check("idle_result_hold", res, 32'd20);

        // Modulo 35 % 15 with starts during busy, including the final iteration edge
        issue32(3'b111, 32'd35, 32'd15);
        check("mod_busy_at_e0", busy, 1);
        check("mod_no_valid_at_e0", valid, 0);
        vcnt = 0; bcnt = 1; vat = -1; res_at = '0; dbz_at = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            if (k == 3 || k == 4 || k == 5 || k == 32) begin
                start = 1'b1; op = 3'b000; a = 32'd1; b = 32'd1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (busy) bcnt++;
            if (valid) begin
                vcnt++;
                if (vat < 0) begin
                    vat = k; res_at = res; dbz_at = dbz;
                end
            end
        end
        start = 1'b0;
        check("mod_valid_count", vcnt, 1);
        check("mod_latency", vat, 32);
        check("mod_busy_cycles", bcnt, 32);
        check("mod_result", res_at, 32'd5);
        check("mod_dbz", dbz_at, 0);

        // Overflow and signed compare corners
        issue32(3'b101, 32'h7FFF_FFFF, 32'd1);
        check("add_ovf_result", res, 32'h8000_0000);
        check("add_ovf_flag", ovf, 1);
        issue32(3'b110, 32'h8000_0000, 32'd1);
        check("sub_ovf_result", res, 32'h7FFF_FFFF);
        check("sub_ovf_flag", ovf, 1);
        issue32(3'b100, 32'hFFFF_FFFF, 32'd1);
        check("slt_neg_result", res, 32'd1);
        check("slt_ovf_clear", ovf, 0);
        issue32(3'b110, 32'd5, 32'd7);
        check("sub_neg_result", res, 32'hFFFF_FFFE);
        check("sub_no_ovf", ovf, 0);

        // Modulo by zero
        issue32(3'b111, 32'd123, 32'd0);
        check("dbz_valid", valid, 1);
        check("dbz_result", res, 32'd123);
        check("dbz_flag", dbz, 1);
        check("dbz_busy", busy, 0);
        @(posedge clk);
        #1;
        check("dbz_busy_next", busy, 0);
        check("dbz_valid_drop", valid, 0);
        issue32(3'b101, 32'd1, 32'd2);
        check("dbz_clear_result", res, 32'd3);
        check("dbz_clear_flag", dbz, 0);

        // Reset mid-MOD
        issue32(3'b111, 32'hFFFF_FFFF, 32'd7);
        repeat (9) @(posedge clk);
        #1;
        check("abort_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("abort_result", res, 0);
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        check("abort_ovf", ovf, 0);
        check("abort_dbz", dbz, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        vcnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (valid) vcnt++;
        end
        check("abort_no_valid", vcnt, 0);
        issue32(3'b111, 32'hFFFF_FFFF, 32'd7);
        wait_valid(1'b0, lat);
        check("mod2_latency", lat, 32);
        check("mod2_result", res, 32'd3);

        // 8-bit instance
        op8 = 3'b111; a8 = 8'd200; b8 = 8'd13; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8_busy_at_e0", busy8, 1);
        wait_valid(1'b1, lat);
        check("w8_mod_latency", lat, 8);
        check("w8_mod_result", res8, 8'd5);
        check("w8_busy_end", busy8, 0);
        op8 = 3'b101; a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        check("w8_add_valid", valid8, 1);
        check("w8_add_result", res8, 8'd44);
        check("w8_add_ovf", ovf8, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
